// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Serializes read/write transactions from several requesters onto the shared
// storage block of the multicycle RV32I core. One transaction is in flight at
// a time. The arbiter latches the winner's fields, drives the storage
// strobes for exactly one cycle, waits MEM_LATENCY cycles on reads, and
// returns a one-cycle ack (plus rdata for reads).
//
// Transaction timeline (T = IDLE cycle that samples req):
//   T      IDLE   winner picked, fields latched
//   T+1    ISSUE  mem_readEn or mem_writeEn high for this cycle only
//   T+2..  WAIT   reads only, MEM_LATENCY cycles, data captured on the last
//   RESP          ack[g] high one cycle; read at T+2+MEM_LATENCY, write at T+2
//
// Handshake: req[i] is a level. A requester keeps req[i] high until it sees
// ack[i], then drops it on the next cycle. The arbiter reads req/reqWe/
// reqAddrs/reqWdatas only in the IDLE cycle that grants. A req still high in
// the IDLE cycle after RESP is taken as a new transaction.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin search starting at pointer
//                       undefined -> fixed priority, lowest index wins
//                                    (pointer held at 0)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   startSig        new grants only while high
//   req, reqWe      per-requester request level and write select
//   reqAddrs        packed addresses, requester i at [ADDR_SIZE*i +: ADDR_SIZE]
//   reqWdatas       packed write data, same packing
//   ack             one-hot one-cycle completion pulse
//   rdata           last captured read data
//   grant           one-hot owner of the in-flight transaction
//   busy            high whenever the FSM is not in IDLE
//   mem_read*/mem_write*  storage port strobes, address and data
//   mem_readData    storage read data
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int ADDR_SIZE   = 28,
  parameter int ROW_WIDTH   = 32,
  parameter int AMT_REQ     = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           startSig,
  input  logic [AMT_REQ-1:0]             req,
  input  logic [AMT_REQ-1:0]             reqWe,
  input  logic [ADDR_SIZE*AMT_REQ-1:0]   reqAddrs,
  input  logic [ROW_WIDTH*AMT_REQ-1:0]   reqWdatas,
  output logic [AMT_REQ-1:0]             ack,
  output logic [ROW_WIDTH-1:0]           rdata,
  output logic [AMT_REQ-1:0]             grant,
  output logic                           busy,
  output logic [ADDR_SIZE-1:0]           mem_readAddr,
  output logic                           mem_readEn,
  output logic [ADDR_SIZE-1:0]           mem_writeAddr,
  output logic [ROW_WIDTH-1:0]           mem_writeData,
  output logic                           mem_writeEn,
  input  logic [ROW_WIDTH-1:0]           mem_readData
);

  localparam int IDX_W = (AMT_REQ > 1) ? $clog2(AMT_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;

  // Latched transaction fields
  logic [AMT_REQ-1:0]   grant_q;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ROW_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ROW_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]     ptr_q;

  // Winner of the current IDLE-cycle search
  logic                 win_found;
  logic [AMT_REQ-1:0]   win_onehot;
  logic                 win_we;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [ROW_WIDTH-1:0] win_wdata;

  logic                 take_req;
  logic                 wait_done;

  // ---------------------------------------------------------------------------
  // Winner search. The search always starts at ptr_q and wraps; in the
  // fixed-priority build ptr_q never leaves 0, so this reduces to
  // lowest-index-wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    cand       = 0;
    win_found  = 1'b0;
    win_onehot = '0;
    win_we     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int k = 0; k < AMT_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= AMT_REQ) cand = cand - AMT_REQ;
      if (!win_found && req[cand]) begin
        win_found        = 1'b1;
        win_onehot[cand] = 1'b1;
        win_we           = reqWe[cand];
        win_addr         = reqAddrs[cand*ADDR_SIZE +: ADDR_SIZE];
        win_wdata        = reqWdatas[cand*ROW_WIDTH +: ROW_WIDTH];
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer value after the current owner: (g + 1) mod AMT_REQ.
  logic [IDX_W-1:0] ptr_adv;
  always_comb begin
    ptr_adv = '0;
    for (int k = 0; k < AMT_REQ; k++) begin
      if (grant_q[k]) begin
        ptr_adv = (k == AMT_REQ - 1) ? '0 : IDX_W'(k + 1);
      end
    end
  end
`endif

  assign take_req  = startSig && win_found;
  // The counter is loaded with MEM_LATENCY on ISSUE; the WAIT cycle that sees
  // 1 is the one where mem_readData is valid, and the counter hits 0 as the
  // FSM leaves WAIT.
  assign wait_done = (cnt_q <= CNT_W'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_done) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_req) begin
            grant_q <= win_onehot;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
          end
        end
        ST_ISSUE: begin
          if (!we_q) cnt_q <= CNT_W'(MEM_LATENCY);
        end
        ST_WAIT: begin
          if (wait_done) begin
            rdata_q <= mem_readData;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          grant_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_q   <= ptr_adv;
`else
          ptr_q   <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobes and ack are masked by rst so nothing reaches the storage
  // or the requesters in the reset cycle, even mid-transaction.
  // ---------------------------------------------------------------------------
  assign mem_readEn    = !rst && (state_q == ST_ISSUE) && !we_q;
  assign mem_writeEn   = !rst && (state_q == ST_ISSUE) &&  we_q;
  assign mem_readAddr  = addr_q;
  assign mem_writeAddr = addr_q;
  assign mem_writeData = wdata_q;

  assign ack   = (!rst && (state_q == ST_RESP)) ? grant_q : '0;
  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Two arbiters share clock and request inputs: dut (MEM_LATENCY=1) and dut3
// (MEM_LATENCY=3). Each has its own small storage model whose read data is a
// poison word except in the cycle it is genuinely valid, so an early or late
// capture shows up as wrong rdata. All expectations are hand-derived
// constants or come from the exp_q scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int NR = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic             startSig;
  logic [NR-1:0]    req;
  logic [NR-1:0]    reqWe;
  logic [AW*NR-1:0] reqAddrs;
  logic [DW*NR-1:0] reqWdatas;

  // ---------------- dut (latency 1) ----------------
  logic [NR-1:0] ack, grant;
  logic [DW-1:0] rdata, mem_writeData, mem_readData;
  logic [AW-1:0] mem_readAddr, mem_writeAddr;
  logic          busy, mem_readEn, mem_writeEn;

  mem_access_arbiter #(.ADDR_SIZE(AW), .ROW_WIDTH(DW), .AMT_REQ(NR), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .startSig(startSig), .req(req), .reqWe(reqWe),
    .reqAddrs(reqAddrs), .reqWdatas(reqWdatas), .ack(ack), .rdata(rdata),
    .grant(grant), .busy(busy), .mem_readAddr(mem_readAddr), .mem_readEn(mem_readEn),
    .mem_writeAddr(mem_writeAddr), .mem_writeData(mem_writeData),
    .mem_writeEn(mem_writeEn), .mem_readData(mem_readData)
  );

  // ---------------- dut3 (latency 3) ----------------
  logic [NR-1:0] ack_3, grant_3;
  logic [DW-1:0] rdata_3, mem_writeData_3, mem_readData_3;
  logic [AW-1:0] mem_readAddr_3, mem_writeAddr_3;
  logic          busy_3, mem_readEn_3, mem_writeEn_3;

  mem_access_arbiter #(.ADDR_SIZE(AW), .ROW_WIDTH(DW), .AMT_REQ(NR), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .startSig(startSig), .req(req), .reqWe(reqWe),
    .reqAddrs(reqAddrs), .reqWdatas(reqWdatas), .ack(ack_3), .rdata(rdata_3),
    .grant(grant_3), .busy(busy_3), .mem_readAddr(mem_readAddr_3), .mem_readEn(mem_readEn_3),
    .mem_writeAddr(mem_writeAddr_3), .mem_writeData(mem_writeData_3),
    .mem_writeEn(mem_writeEn_3), .mem_readData(mem_readData_3)
  );

  // ---------------- storage models ----------------
  logic [DW-1:0] mem1 [0:255];
  logic [DW-1:0] mem3 [0:255];
  logic [DW-1:0] p0, p1, p2;

  always @(posedge clk) begin
    if (rst) mem1[8'h10] <= 32'hDEADBEEF;
    else if (mem_writeEn) mem1[mem_writeAddr[7:0]] <= mem_writeData;
    mem_readData <= mem_readEn ? mem1[mem_readAddr[7:0]] : 32'hBAD0_0001;
  end

  always @(posedge clk) begin
    if (rst) mem3[8'h10] <= 32'hDEADBEEF;
    else if (mem_writeEn_3) mem3[mem_writeAddr_3[7:0]] <= mem_writeData_3;
    p0 <= mem_readEn_3 ? mem3[mem_readAddr_3[7:0]] : 32'hBAD0_0003;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_readData_3 = p2;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [NR-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    req[idx]                 = 1'b1;
    reqWe[idx]               = we;
    reqAddrs[idx*AW +: AW]   = addr;
    reqWdatas[idx*DW +: DW]  = wdata;
  endtask

  // Ticks until dut acks; lat = cycles after the sampling cycle, -1 on timeout.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ack != '0) begin
        lat = i;
        return;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int got_n;
    int cyc;
    logic [NR-1:0] e;
    logic [NR-1:0] seen;

    rst = 1'b1; startSig = 1'b0; req = '0; reqWe = '0; reqAddrs = '0; reqWdatas = '0;
    tick(); tick();
    check("rst_rd_en", mem_readEn, 0);
    check("rst_wr_en", mem_writeEn, 0);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy3", busy_3, 0);

    // ---- single read of 0x10, addr changed after latching ----
    startSig = 1'b1;
    set_req(0, 1'b0, 28'h10, 32'h0);                   // T
    tick();                                            // T+1
    reqAddrs[0 +: AW] = 28'h20;
    check("rd_issue_en", mem_readEn, 1);
    check("rd_issue_addr", mem_readAddr, 32'h10);
    check("rd_issue_wren", mem_writeEn, 0);
    check("rd_issue_grant", grant, 2'b01);
    check("rd_issue_busy", busy, 1);
    check("rd_issue_en3", mem_readEn_3, 1);
    tick();                                            // T+2
    check("rd_wait_ack", ack, 0);
    check("rd_wait_en", mem_readEn, 0);
    tick();                                            // T+3
    check("rd_ack", ack, 2'b01);
    check("rd_data", rdata, 32'hDEADBEEF);
    check("rd_ack3_early", ack_3, 0);
    tick();                                            // T+4
    req = '0;
    check("rd_ack_pulse", ack, 0);
    check("rd_busy_done", busy, 0);
    check("rd3_busy", busy_3, 1);
    check("rd3_no_early_capture", rdata_3, 0);
    tick();                                            // T+5
    check("rd3_ack", ack_3, 2'b01);
    check("rd3_data", rdata_3, 32'hDEADBEEF);
    check("rd3_busy_resp", busy_3, 1);
    tick();                                            // T+6
    check("rd3_idle", busy_3, 0);

    // ---- single write by requester 1 ----
    set_req(1, 1'b1, 28'h20, 32'h12345678);            // T
    tick();                                            // T+1
    check("wr_en", mem_writeEn, 1);
    check("wr_addr", mem_writeAddr, 32'h20);
    check("wr_data", mem_writeData, 32'h12345678);
    check("wr_rd_en", mem_readEn, 0);
    check("wr_grant", grant, 2'b10);
    tick();                                            // T+2
    check("wr_ack", ack, 2'b10);
    check("wr_rdata_kept", rdata, 32'hDEADBEEF);
    check("wr_ack3", ack_3, 2'b10);
    tick();
    req = '0; reqWe = '0;
    check("wr_ack_pulse", ack, 0);

    // ---- read back 0x20 ----
    set_req(0, 1'b0, 28'h20, 32'h0);
    wait_ack(lat);
    check("rb_latency", lat, 3);
    check("rb_ack", ack, 2'b01);
    check("rb_data", rdata, 32'h12345678);
    tick(); req = '0;
    tick(); tick();
    check("rb3_data", rdata_3, 32'h12345678);

    // ---- reset during ISSUE: strobes masked in the reset cycle ----
    set_req(0, 1'b0, 28'h10, 32'h0);                   // T
    tick();                                            // T+1 ISSUE
    rst = 1'b1;
    #1;
    check("rst_issue_rd_en", mem_readEn, 0);
    check("rst_issue_rd_en3", mem_readEn_3, 0);
    check("rst_issue_ack", ack, 0);
    tick();                                            // idle again, req still high
    rst = 1'b0;
    check("rst_issue_busy", busy, 0);
    check("rst_issue_grant", grant, 0);

    // ---- reset during WAIT ----
    tick();                                            // ISSUE
    tick();                                            // WAIT for both
    check("wait_busy", busy, 1);
    check("wait_busy3", busy_3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    check("rwait_ack", ack, 0);
    check("rwait_grant", grant, 0);
    check("rwait_busy", busy, 0);
    check("rwait_rdata", rdata, 0);
    check("rwait_rd_en", mem_readEn, 0);
    check("rwait_wr_en", mem_writeEn, 0);
    check("rwait_rd_addr", mem_readAddr, 0);
    check("rwait_busy3", busy_3, 0);
    check("rwait_rdata3", rdata_3, 0);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ack | ack_3;
    end
    check("rwait_no_ack", seen, 0);

    // ---- startSig low blocks grants ----
    startSig = 1'b0;
    set_req(0, 1'b0, 28'h10, 32'h0);
    set_req(1, 1'b0, 28'h20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nostart_grant", grant, 0);
      check("nostart_busy", busy, 0);
      check("nostart_rd_en", mem_readEn, 0);
      check("nostart_wr_en", mem_writeEn, 0);
    end
    startSig = 1'b1;                                   // T
    tick();                                            // T+1
    check("start_grant", grant, 2'b01);
    check("start_rd_en", mem_readEn, 1);

    // ---- contention: both held high for 4 transactions ----
`ifdef ARB_ROUND_ROBIN_EN
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    got_n = 0;
    cyc = 1;
    for (int i = 0; i < 30 && got_n < 4; i++) begin
      tick();
      cyc++;
      if (ack != '0) begin
        e = exp_q.pop_front();
        check("cont_grant", ack, e);
        check("cont_data", rdata, (e == 2'b01) ? 32'hDEADBEEF : 32'h12345678);
        check("cont_cycle", cyc, 3 + 4 * got_n);
        got_n++;
      end
    end
    check("cont_count", got_n, 4);
    req = '0;
    tick(); tick(); tick(); tick();
    check("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Sequences all accesses to the shared single-port-write storage block for the multicycle RV32I core. Several requesters (instruction fetch, load/store unit, debug/loader) issue read or write transactions. The arbiter serializes them one at a time, drives the storage read/write strobes, waits a fixed latency, and returns data with a one-cycle ack. The storage sees at most one enable per cycle, so its internal priority chain is never exercised.

Parameters:
ADDR_SIZE, 28, word address width (matches storage READ_ADDR_SIZE)
ROW_WIDTH, 32, data word width
AMT_REQ, 2, number of requesters; index 0 = fetch
MEM_LATENCY, 1, cycles from read enable edge to valid mem_readData (>=1)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
startSig  input  1  core started; new grants only while high
req  input  AMT_REQ  per-requester request, level
reqWe  input  AMT_REQ  per-requester 1=write, 0=read
reqAddrs  input  ADDR_SIZE*AMT_REQ  packed addresses, requester i at [ADDR_SIZE*(i+1)-1 : ADDR_SIZE*i]
reqWdatas  input  ROW_WIDTH*AMT_REQ  packed write data, same packing
ack  output  AMT_REQ  one-hot, one-cycle completion pulse
rdata  output  ROW_WIDTH  read data, valid while ack high
grant  output  AMT_REQ  one-hot owner of the in-flight transaction
busy  output  1  high in any state except IDLE
mem_readAddr  output  ADDR_SIZE  to storage reader 0 address
mem_readEn  output  1  to storage readEns[0]
mem_writeAddr  output  ADDR_SIZE  to storage writeAddr
mem_writeData  output  ROW_WIDTH  to storage writeData
mem_writeEn  output  1  to storage writeEn
mem_readData  input  ROW_WIDTH  from storage poolReadData

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if startSig and |req, select winner g and latch its addr, we and wdata. Set grant to one-hot g. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE, exactly 1 cycle: read drives mem_readEn=1 and mem_readAddr; write drives mem_writeEn=1, mem_writeAddr and mem_writeData. Read goes to WAIT with counter=MEM_LATENCY. Write goes directly to RESP.
- WAIT: decrement counter each cycle. When counter reaches 0, capture mem_readData into rdata and go to RESP.
- RESP: ack[g]=1 for 1 cycle. Advance the priority pointer. Clear grant. Go to IDLE.
- Read ack arrives at T+2+MEM_LATENCY, where T is the IDLE cycle that sampled req. Write ack arrives at T+2. Minimum issue spacing is back-to-back: IDLE follows RESP.
- Requester holds req until it sees ack, then deasserts next cycle. A req still high in the IDLE cycle after RESP counts as a new transaction.
- Request inputs are ignored after latching. Dropping req or changing addr mid-transaction does not abort the transaction or change it; ack still fires.
- Strobes are combinational from state and latched fields. mem_readEn and mem_writeEn are never high simultaneously. Both are 0 outside ISSUE.
- rdata holds its last captured value. Write acks leave rdata unchanged.
- startSig low: no new grants; an in-flight transaction completes normally.
- Reset, including mid-transaction: state=IDLE, grant=0, ack=0, busy=0, rdata=0, pointer=0, counter=0. The abandoned transaction gets no ack. All strobes are 0 in the reset cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round-robin. The search starts at pointer and wraps modulo AMT_REQ. In RESP, pointer becomes (g+1) mod AMT_REQ.
- Undefined: fixed priority, lowest index wins. The pointer is unused and held at 0.

Test Plan:
- Single read, MEM_LATENCY=1: rst, then startSig=1, req=01, reqWe=0, addr0=0x10 with mem[0x10]=0xDEADBEEF -> mem_readEn pulses 1 cycle with addr 0x10; ack=01 at T+3; rdata=0xDEADBEEF.
- Single write: req=10, reqWe=10, addr1=0x20, wdata1=0x12345678 -> mem_writeEn 1 cycle at T+1 with those values; ack=10 at T+2; a subsequent read of 0x20 returns 0x12345678.
- Contention, both requesters held high for 4 transactions -> with ARB_ROUND_ROBIN_EN grants go 0,1,0,1; without it grants go 0,0,0,0.
- MEM_LATENCY=3 read -> ack at T+5; busy high T+1..T+5; mem_readData sampled only at the counter-zero cycle.
- Reset asserted during WAIT -> next cycle all outputs 0 and state IDLE; no ack for the aborted request; the next req is serviced normally.
- startSig=0 with req=11 -> no grant, busy=0, no strobes; raising startSig starts a grant in the next IDLE sample.
